// File: rtl/dot_product_layer_sequencer.sv
// Layer sequencer for a fixed-weight dot-product datapath: per neuron it shifts in the
// weight vector, streams the shared input vector, and captures the result for a consumer.
module dot_product_layer_sequencer #(
  parameter int BITS    = 16,
  parameter int LENGTH  = 10,
  parameter int MULTS   = 2,
  parameter int NEURONS = 4,
  parameter int TIMEOUT = 64,
  localparam int BEATS  = LENGTH / MULTS,
  localparam int WAW    = (NEURONS * BEATS > 1) ? $clog2(NEURONS * BEATS) : 1,
  localparam int XAW    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int NW     = (NEURONS > 1) ? $clog2(NEURONS) : 1,
  localparam int WCW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       w_en,
  output logic [WAW-1:0]             w_addr,
  input  logic [MULTS-1:0][BITS-1:0] w_data,
  output logic                       x_en,
  output logic [XAW-1:0]             x_addr,
  input  logic [MULTS-1:0][BITS-1:0] x_data,
  output logic                       load_a,
  output logic [MULTS-1:0][BITS-1:0] vector_a_in,
  output logic                       in_valid,
  output logic [MULTS-1:0][BITS-1:0] vector_b,
  input  logic                       out_valid,
  input  logic [BITS-1:0]            c,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [BITS-1:0]            res_data,
  output logic [NW-1:0]              res_index
);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, WAIT, OUT} state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q, n_d;
  logic [XAW-1:0]  k_q, k_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic            w_en_d, x_en_d, load_a_d, in_valid_d;
  logic            busy_d, done_d, err_d, res_valid_d;
  logic [WAW-1:0]  w_addr_d;
  logic [XAW-1:0]  x_addr_d;
  logic [BITS-1:0] res_data_d;
  logic [NW-1:0]   res_index_d;

  assign vector_a_in = w_data;
  assign vector_b    = x_data;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    wcnt_d      = wcnt_q;
    w_en_d      = 1'b0;
    w_addr_d    = w_addr;
    x_en_d      = 1'b0;
    x_addr_d    = x_addr;
    load_a_d    = w_en;
    in_valid_d  = x_en;
    done_d      = 1'b0;
    err_d       = err;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_index_d = res_index;

    if (abort) begin
      state_d     = IDLE;
      load_a_d    = 1'b0;
      in_valid_d  = 1'b0;
      res_valid_d = 1'b0;
      done_d      = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            n_d      = '0;
            err_d    = 1'b0;
            state_d  = LOAD;
            w_en_d   = 1'b1;
            w_addr_d = WAW'(BEATS - 1);
            k_d      = XAW'(BEATS - 1);
          end
        end
        // Weights are read last beat first so the shift register ends up beat-aligned;
        // the cycle after the final read is spent on the trailing load_a.
        LOAD: begin
          if (w_en) begin
            if (k_q != '0) begin
              w_en_d   = 1'b1;
              w_addr_d = w_addr - WAW'(1);
              k_d      = k_q - XAW'(1);
            end
          end else begin
            state_d  = STREAM;
            x_en_d   = 1'b1;
            x_addr_d = '0;
          end
        end
        STREAM: begin
          if (x_en) begin
            if (x_addr != XAW'(BEATS - 1)) begin
              x_en_d   = 1'b1;
              x_addr_d = x_addr + XAW'(1);
            end
          end else begin
            state_d = WAIT;
            wcnt_d  = '0;
          end
        end
        WAIT: begin
          if (out_valid) begin
            res_data_d  = c;
            res_index_d = n_q;
            res_valid_d = 1'b1;
            state_d     = OUT;
          end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            if (n_q != NW'(NEURONS - 1)) begin
              n_d      = n_q + NW'(1);
              state_d  = LOAD;
              w_en_d   = 1'b1;
              w_addr_d = WAW'((int'(n_q) + 1) * BEATS + BEATS - 1);
              k_d      = XAW'(BEATS - 1);
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      n_q       <= '0;
      k_q       <= '0;
      wcnt_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      x_en      <= 1'b0;
      x_addr    <= '0;
      load_a    <= 1'b0;
      in_valid  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      k_q       <= k_d;
      wcnt_q    <= wcnt_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      w_en      <= w_en_d;
      w_addr    <= w_addr_d;
      x_en      <= x_en_d;
      x_addr    <= x_addr_d;
      load_a    <= load_a_d;
      in_valid  <= in_valid_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      res_index <= res_index_d;
    end
  end

endmodule

// File: tb/tb_dot_product_layer_sequencer.sv
// Bench for dot_product_layer_sequencer: memory and datapath models, strobe timing table,
// result scoreboard, and directed hold/timeout/abort/reset sequences.
module tb_dot_product_layer_sequencer;
  localparam int BITS = 16, LENGTH = 10, MULTS = 2, NEURONS = 4, TIMEOUT = 64;
  localparam int BEATS = LENGTH / MULTS;
  localparam int DP_LAT = 2;
  localparam int ROWS = 2 * BEATS + 4;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic busy, done, err, w_en, x_en, load_a, in_valid, res_valid;
  logic [4:0] w_addr;
  logic [2:0] x_addr;
  logic [1:0] res_index;
  logic [BITS-1:0] res_data, c, dp_c, frc_c;
  logic out_valid, dp_ov, frc_ov;
  logic dp_en;
  logic [MULTS-1:0][BITS-1:0] w_data, x_data, vector_a_in, vector_b;

  assign out_valid = dp_ov | frc_ov;
  assign c = frc_ov ? frc_c : dp_c;

  dot_product_layer_sequencer #(.BITS(BITS), .LENGTH(LENGTH), .MULTS(MULTS),
    .NEURONS(NEURONS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .busy(busy), .done(done),
    .err(err), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .x_en(x_en),
    .x_addr(x_addr), .x_data(x_data), .load_a(load_a), .vector_a_in(vector_a_in),
    .in_valid(in_valid), .vector_b(vector_b), .out_valid(out_valid), .c(c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_index(res_index));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Memories: weight beat n*BEATS+k holds n+1 in every lane, input element i holds i.
  always @(posedge clk) begin
    if (w_en) for (int m = 0; m < MULTS; m++) w_data[m] <= BITS'(int'(w_addr) / BEATS + 1);
    if (x_en) for (int m = 0; m < MULTS; m++) x_data[m] <= BITS'(int'(x_addr) * MULTS + m);
  end

  // Datapath: shift register places the first-shifted beat at the top index.
  logic [MULTS-1:0][BITS-1:0] areg [BEATS];
  int dp_beat = 0, dp_acc = 0, dp_cd = 0, dp_res = 0;
  always @(posedge clk) begin
    dp_ov <= 1'b0;
    if (!rstn || abort) begin
      dp_beat = 0; dp_acc = 0; dp_cd = 0;
    end else begin
      if (dp_cd > 0) begin
        dp_cd--;
        if (dp_cd == 0 && dp_en) begin dp_ov <= 1'b1; dp_c <= BITS'(dp_res); end
      end
      if (load_a) begin
        for (int i = BEATS - 1; i > 0; i--) areg[i] <= areg[i-1];
        areg[0] <= vector_a_in;
      end
      if (in_valid) begin
        for (int m = 0; m < MULTS; m++) dp_acc += int'(areg[dp_beat][m]) * int'(vector_b[m]);
        dp_beat++;
        if (dp_beat == BEATS) begin dp_res = dp_acc; dp_acc = 0; dp_beat = 0; dp_cd = DP_LAT; end
      end
    end
  end

  typedef struct {int idx; int data;} exp_t;
  exp_t sb[$];
  int done_cnt = 0, overlap_cnt = 0;

  task automatic push_layer();
    for (int n = 0; n < NEURONS; n++) sb.push_back('{n, (n + 1) * LENGTH * (LENGTH - 1) / 2});
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (load_a && in_valid) overlap_cnt++;
    if (res_valid && res_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 64'(res_index), 64'hFFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_index", 64'(res_index), 64'(e.idx));
        chk("res_data", 64'(res_data), 64'(e.data));
      end
    end
  end

  function automatic logic [63:0] outs_vec();
    return 64'({busy, done, err, w_en, x_en, load_a, in_valid, res_valid,
                w_addr, x_addr, res_data, res_index});
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_to_done(input string nm, input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 600) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_all_results"}, 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    logic start;
    logic busy, w_en, load_a, x_en, in_valid;
    int w_addr, x_addr;
  } row_t;
  row_t tbl[ROWS];

  initial begin
    int k, d0, cnt, bad, wbad;
    logic [BITS-1:0] hd;
    logic [1:0] hi;
    logic we_a[2*BEATS+2], la_a[2*BEATS+2];
    int wa_a[BEATS], xa_a[BEATS], nw, nx, nl;

    for (int j = 0; j < ROWS; j++) begin
      tbl[j].start    = (j == 0 || j == 3 || j == 8);
      tbl[j].busy     = (j >= 1);
      tbl[j].w_en     = (j >= 1 && j <= BEATS);
      tbl[j].w_addr   = tbl[j].w_en ? BEATS - j : 0;
      tbl[j].load_a   = (j >= 2 && j <= BEATS + 1);
      tbl[j].x_en     = (j >= BEATS + 2 && j <= 2 * BEATS + 1);
      tbl[j].x_addr   = tbl[j].x_en ? j - (BEATS + 2) : 0;
      tbl[j].in_valid = (j >= BEATS + 3 && j <= 2 * BEATS + 2);
    end
    dp_en = 1'b1; frc_ov = 1'b0; frc_c = '0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_vec(), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Full layer: strobe timing table for neuron 0, start repeated while busy.
    push_layer();
    d0 = done_cnt;
    for (int j = 0; j < ROWS; j++) begin
      @(posedge clk); #1 start = tbl[j].start;
      @(negedge clk);
      chk($sformatf("timing_row%0d", j),
          64'({busy, w_en, load_a, x_en, in_valid, 5'(w_en ? w_addr : 5'd0), 3'(x_en ? x_addr : 3'd0)}),
          64'({tbl[j].busy, tbl[j].w_en, tbl[j].load_a, tbl[j].x_en, tbl[j].in_valid,
               5'(tbl[j].w_addr), 3'(tbl[j].x_addr)}));
    end
    #1 start = 1'b0;

    // Neuron 2 strobe order, captured right after the neuron 1 handshake.
    k = 0;
    while (!(res_valid && res_index == 2'd1) && k < 300) begin @(negedge clk); k++; end
    chk("n1_result_seen", 64'(k < 300), 64'd1);
    nw = 0; nx = 0; nl = 0;
    for (int i = 0; i < BEATS; i++) begin wa_a[i] = 99; xa_a[i] = 99; end
    for (int j = 0; j < 2 * BEATS + 2; j++) begin
      @(negedge clk);
      we_a[j] = w_en; la_a[j] = load_a;
      if (w_en) begin if (nw < BEATS) wa_a[nw] = int'(w_addr); nw++; end
      if (x_en) begin if (nx < BEATS) xa_a[nx] = int'(x_addr); nx++; end
      if (load_a) nl++;
    end
    chk("wen_after_handshake", 64'(we_a[0]), 64'd1);
    chk("n2_w_en_count", 64'(nw), 64'(BEATS));
    for (int i = 0; i < BEATS; i++)
      chk($sformatf("n2_w_addr%0d", i), 64'(wa_a[i]), 64'(3 * BEATS - 1 - i));
    chk("n2_load_a_count", 64'(nl), 64'(BEATS));
    bad = (la_a[0] != 1'b0) ? 1 : 0;
    for (int j = 1; j < 2 * BEATS + 2; j++) if (la_a[j] != we_a[j-1]) bad++;
    chk("n2_load_a_follows_w_en", 64'(bad), 64'd0);
    chk("n2_x_en_count", 64'(nx), 64'(BEATS));
    for (int i = 0; i < BEATS; i++) chk($sformatf("n2_x_addr%0d", i), 64'(xa_a[i]), 64'(i));
    run_to_done("layer1", d0);
    chk("no_load_stream_overlap", 64'(overlap_cnt), 64'd0);

    // Consumer stalls at neuron 1; a stray out_valid in OUT must be ignored.
    res_ready = 1'b0;
    push_layer();
    d0 = done_cnt;
    pulse_start();
    k = 0;
    while (!res_valid && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    k = 0;
    while (!res_valid && k < 200) begin @(negedge clk); k++; end
    chk("hold_result_seen", 64'(k < 200), 64'd1);
    hd = res_data; hi = res_index;
    chk("hold_index", 64'(hi), 64'd1);
    bad = 0; wbad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 frc_ov = (i == 5); frc_c = 16'hBEEF;
      @(negedge clk);
      if (!res_valid || res_data !== hd || res_index !== hi) bad++;
      if (w_en) wbad++;
    end
    #1 frc_ov = 1'b0;
    chk("hold_stable", 64'(bad), 64'd0);
    chk("hold_no_w_en", 64'(wbad), 64'd0);
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk); chk("hold_w_en_before_hs", 64'(w_en), 64'd0);
    @(negedge clk); chk("hold_w_en_after_hs", 64'(w_en), 64'd1);
    run_to_done("layer_hold", d0);

    // Datapath never answers: timeout 64 cycles after WAIT entry (cycle 2*BEATS+3).
    dp_en = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int j = 1; j <= 2 * BEATS + 3 + TIMEOUT + 1; j++) begin
      @(negedge clk);
      if (j == 2 * BEATS + 2 + TIMEOUT) chk("tmo_before", 64'({done, err, busy}), 64'b001);
      if (j == 2 * BEATS + 3 + TIMEOUT) chk("tmo_fire", 64'({done, err, busy}), 64'b110);
      if (j == 2 * BEATS + 4 + TIMEOUT) chk("tmo_after", 64'({done, err, busy}), 64'b010);
    end
    chk("tmo_done_pulses", 64'(done_cnt - d0), 64'd1);
    dp_en = 1'b1;
    push_layer();
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    chk("err_cleared_by_start", 64'(err), 64'd0);
    run_to_done("layer_after_tmo", d0);

    // Abort in the middle of neuron 1's input stream.
    push_layer();
    d0 = done_cnt;
    pulse_start();
    k = 0;
    while (!(w_en && w_addr == 5'(2 * BEATS - 1)) && k < 200) begin @(negedge clk); k++; end
    chk("n1_load_seen", 64'(k < 200), 64'd1);
    repeat (BEATS + 2) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk); chk("pre_abort_streaming", 64'({x_en, in_valid}), 64'b11);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'({x_en, in_valid, w_en, load_a, res_valid, busy, done}), 64'b0000001);
    @(negedge clk); chk("abort_done_single", 64'(done), 64'd0);
    chk("abort_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("abort_n0_only", 64'(sb.size()), 64'(NEURONS - 1));
    sb.delete();
    push_layer();
    d0 = done_cnt;
    pulse_start();
    run_to_done("layer_after_abort", d0);

    // Reset during LOAD.
    pulse_start();
    @(posedge clk); #1 rstn = 1'b0;
    #1 chk("midrun_reset_immediate", outs_vec(), 64'd0);
    @(negedge clk); chk("midrun_reset_held", outs_vec(), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    push_layer();
    d0 = done_cnt;
    pulse_start();
    run_to_done("layer_after_reset", d0);
    chk("final_no_overlap", 64'(overlap_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/dot_product_layer_sequencer.md
# dot_product_layer_sequencer

Control block that drives one fixed-weight vector dot-product datapath through a full layer. For each of NEURONS output neurons it fetches that neuron's weight vector from a synchronous-read weight memory and shifts it into the datapath's weight register. It then streams the shared input vector from a synchronous-read input memory and captures the datapath result into a valid/ready output register. It sits between the layer memories and the datapath, and runs once per `start`.

## Interface
- BITS, 16, element and result width
- LENGTH, 10, elements per vector; must be a multiple of MULTS
- MULTS, 2, elements per beat (datapath multiplier count); BEATS = LENGTH/MULTS
- NEURONS, 4, neurons per layer
- TIMEOUT, 64, maximum WAIT cycles before abort
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin layer; sampled only in IDLE
- abort  in  1  synchronous abort; return to IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of layer, normal or aborted
- err  out  1  sticky timeout flag; cleared by next accepted `start`
- w_en  out  1  weight memory read enable
- w_addr  out  $clog2(NEURONS*BEATS)  weight beat address = n*BEATS + k
- w_data  in  BITS x MULTS  weight beat; valid 1 cycle after w_en
- x_en  out  1  input memory read enable
- x_addr  out  $clog2(BEATS)  input beat address k
- x_data  in  BITS x MULTS  input beat; valid 1 cycle after x_en
- load_a  out  1  datapath weight shift strobe
- vector_a_in  out  BITS x MULTS  equals w_data, combinational
- in_valid  out  1  datapath beat strobe
- vector_b  out  BITS x MULTS  equals x_data, combinational
- out_valid  in  1  datapath result strobe
- c  in  BITS  datapath result
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts
- res_data  out  BITS  captured result
- res_index  out  $clog2(NEURONS)  neuron index of res_data

## Operation
- States: IDLE, LOAD, STREAM, WAIT, OUT.
- IDLE, start=1: n←0, clear err, go to LOAD. `start` in any other state is ignored.
- LOAD: issue BEATS weight reads in reverse beat order, k = BEATS-1 down to 0. The datapath shift register places the first-shifted beat at the highest index, so reverse order aligns beat k with input beat k. load_a is w_en delayed one cycle. Go to STREAM after the last load_a.
- STREAM: issue BEATS input reads, k = 0 up to BEATS-1. in_valid is x_en delayed one cycle. The BEATS in_valid cycles are contiguous. Go to WAIT after the last in_valid.
- WAIT: on out_valid, capture c into res_data and n into res_index, set res_valid, go to OUT.
  - WAIT cycle counter reaching TIMEOUT: set err, pulse done, go to IDLE.
- OUT: hold res_valid, res_data and res_index stable until res_ready.
  - On handshake with n<NEURONS-1: n←n+1, go to LOAD.
  - On handshake with n=NEURONS-1: pulse done, go to IDLE.
- out_valid outside WAIT is ignored and does not change res_*.
- abort has priority over all transitions. Next cycle: state IDLE, all strobes low, res_valid low, done pulses. err is unchanged.

## Timing
- Reset values: busy=0, done=0, err=0, w_en=0, x_en=0, load_a=0, in_valid=0, res_valid=0, w_addr=0, x_addr=0, res_data=0, res_index=0.
- All control outputs are registered. vector_a_in and vector_b are pass-through.
- `start` at cycle 0 gives:
  - w_en in cycles 1..BEATS;
  - load_a in cycles 2..BEATS+1;
  - x_en in cycles BEATS+2..2·BEATS+1;
  - in_valid in cycles BEATS+3..2·BEATS+2.
- Per-neuron overhead outside WAIT/OUT is 2·BEATS+2 cycles. With BEATS=5 that is 12.
- res_valid rises the cycle after out_valid.
- An OUT handshake in cycle t gives w_en for the next neuron in cycle t+1.
- load_a and in_valid never overlap. No memory read is issued outside LOAD/STREAM.
- Reset asserted mid-operation: all outputs return to reset values immediately. Pending reads are discarded.

## Test plan
- Weight ROM with w[n][i] = n+1, x[i] = i, defaults, start once, res_ready=1 -> four results in order. res_index 0..3, each matching the datapath's c (45·(n+1) for a correct datapath). One done pulse.
- Check strobe order during LOAD for neuron 2 -> w_addr sequence 14,13,12,11,10. load_a high exactly 5 cycles, each one cycle after w_en. Then x_addr 0..4.
- Hold res_ready=0 for 20 cycles at neuron 1 -> res_valid, res_data and res_index stay stable. No w_en until the cycle after res_ready rises.
- Datapath never returns out_valid, TIMEOUT=64 -> err=1 and done pulse 64 cycles after entering WAIT, then IDLE. The next start clears err.
- abort during STREAM of neuron 1 -> in_valid and x_en low the next cycle, done pulse, busy=0. A later start restarts at res_index 0.
- rstn low for 1 cycle during LOAD, then start -> all outputs at reset values while rstn is low. A full, correct four-result layer follows.
